// File: rtl/mnist_pixel_streamer.sv
// Host-side initiator for the MNIST core: buffers one image, streams it
// into the core after a one-cycle core reset, then waits for the classified digit.
module mnist_pixel_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PIXELS = 784,
  parameter int TIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_PIXELS)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          core_rst,
  output logic                          core_i_valid,
  output logic [DATA_WIDTH-1:0]         core_pixel,
  input  logic                          core_o_valid,
  input  logic [3:0]                    core_digit,
  output logic                          result_valid,
  output logic [3:0]                    result_digit,
  output logic                          result_err
);
  localparam int AW = $clog2(NUM_PIXELS);
  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] PIX_END = CW'(NUM_PIXELS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   ADDR_LIM = (AW+1)'(NUM_PIXELS);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, WAIT, DONE} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] mem [NUM_PIXELS];
  logic [CW-1:0]         pix_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  wr_ok;

  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < ADDR_LIM);

  // Image buffer is deliberately not reset so a reload is optional between runs.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLR;
      CLR:     state_nx = STREAM;
      STREAM:  if (pix_cnt == PIX_END) state_nx = WAIT;
      WAIT:    if (core_o_valid || (to_cnt == TO_LAST)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == CLR) || (state == STREAM) || (state == WAIT);
    core_rst     = rst || (state == CLR);
    result_valid = (state == DONE);
  end

  // pix_cnt is the address of the next pixel to fetch; the fetch lands
  // directly in core_pixel so each pixel appears one cycle after its read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt      <= '0;
      to_cnt       <= '0;
      core_i_valid <= 1'b0;
      core_pixel   <= '0;
      result_digit <= 4'd0;
      result_err   <= 1'b0;
    end else begin
      case (state)
        CLR: begin
          core_pixel   <= mem[0];
          core_i_valid <= 1'b1;
          pix_cnt      <= CW'(1);
          to_cnt       <= '0;
        end
        STREAM: begin
          if (pix_cnt == PIX_END) begin
            core_i_valid <= 1'b0;
            pix_cnt      <= '0;
          end else begin
            core_pixel <= mem[pix_cnt[AW-1:0]];
            pix_cnt    <= pix_cnt + CW'(1);
          end
        end
        WAIT: begin
          if (core_o_valid) begin
            result_digit <= core_digit;
            result_err   <= (core_digit > 4'd9);
            to_cnt       <= '0;
          end else if (to_cnt == TO_LAST) begin
            result_digit <= 4'hF;
            result_err   <= 1'b1;
            to_cnt       <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mnist_pixel_streamer.sv
// Randomized bench: a cycle-schedule model derived from the start cycle predicts
// every output each cycle; a few literal checks pin the model itself.
module tb_mnist_pixel_streamer;
  localparam int DW = 8;
  localparam int NP = 784;
  localparam int TO = 100;
  localparam int AW = $clog2(NP);

  logic clk = 0, rst = 1, wr_en = 0, start = 0, core_o_valid = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    core_digit = '0;
  logic busy, core_rst, core_i_valid, result_valid, result_err;
  logic [DW-1:0] core_pixel;
  logic [3:0]    result_digit;

  mnist_pixel_streamer #(.DATA_WIDTH(DW), .NUM_PIXELS(NP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .core_rst(core_rst), .core_i_valid(core_i_valid),
    .core_pixel(core_pixel), .core_o_valid(core_o_valid), .core_digit(core_digit),
    .result_valid(result_valid), .result_digit(result_digit), .result_err(result_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [DW-1:0] img [NP];
  int t_start = -1;
  int p_d = 0, tid = 0;
  bit p_resp = 0;
  logic [3:0] p_dig = 0;
  logic [DW-1:0] e_pix = 0;
  logic [3:0] e_rdig = 0;
  logic e_rerr = 0;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
    end
  endfunction

  // Model: every expectation follows from the accepted start cycle T and the plan.
  always @(negedge clk) begin
    int w, dn;
    bit act, iv_e, rv_e, re_e;
    logic [3:0] rd_e;
    if (rst) begin
      chk("core_rst_in_reset", core_rst, 1);
      t_start = -1; e_pix = 0; e_rdig = 0; e_rerr = 0;
    end else begin
      act  = t_start >= 0;
      w    = t_start + 2 + NP;
      dn   = p_resp ? w + p_d + 1 : w + TO;
      iv_e = act && cyc >= t_start + 2 && cyc <= t_start + 1 + NP;
      if (iv_e) e_pix = img[cyc - t_start - 2];
      rv_e = act && cyc == dn;
      rd_e = e_rdig; re_e = e_rerr;
      if (rv_e) begin
        rd_e = p_resp ? p_dig : 4'hF;
        re_e = p_resp ? (p_dig > 4'd9) : 1'b1;
      end
      chk("busy", busy, act && cyc >= t_start + 1 && cyc < dn);
      chk("core_rst", core_rst, act && cyc == t_start + 1);
      chk("core_i_valid", core_i_valid, iv_e);
      chk("core_pixel", core_pixel, e_pix);
      chk("result_valid", result_valid, rv_e);
      chk("result_digit", result_digit, rd_e);
      chk("result_err", result_err, re_e);
      if (act && tid == 1) begin
        if (cyc == t_start + 2 + 255) chk("lit_pix255", core_pixel, 8'hFF);
        if (cyc == t_start + 2 + 256) chk("lit_pix256", core_pixel, 8'h00);
        if (cyc == t_start + 1 + NP)  chk("lit_pix_last", core_pixel, 8'd15);
        if (cyc == t_start + 2 + NP)  chk("lit_valid_off", core_i_valid, 0);
        if (cyc == t_start + 2 + NP + 11) chk("lit_digit7", {result_valid, result_digit}, 5'h17);
      end
      if (act && tid == 2 && cyc == t_start + 2 + NP + 100)
        chk("lit_timeout", {result_valid, result_err, result_digit}, 6'h3F);
      if (act && tid == 3 && rv_e) chk("lit_digit12", {result_err, result_digit}, 5'h1C);
      if (act && tid == 8 && rv_e) chk("lit_tie", {result_err, result_digit}, 5'h03);
      if (rv_e) begin
        e_rdig = rd_e; e_rerr = re_e; t_start = -1;
      end else if (!act && start) t_start = cyc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
    if (a < NP) img[a] = d;
    step();
    wr_en = 0;
  endtask

  task automatic run(input int d, input bit resp, input logic [3:0] dig,
                     input bit noise, input int rst_at, input int id);
    int t, n;
    p_d = d; p_resp = resp; p_dig = dig; tid = id;
    start = 1; step(); start = 0;
    t = t_start;
    if (noise) begin
      repeat (20) step();
      for (int i = 0; i < 30; i++) begin
        start = 1; wr_en = 1; wr_addr = AW'($urandom_range(NP - 1)); wr_data = DW'($urandom);
        core_o_valid = (i == 5); core_digit = 4'd2;
        step();
      end
      start = 0; wr_en = 0; core_o_valid = 0;
    end
    if (rst_at >= 0) begin
      while (cyc < t + 2 + rst_at) step();
      rst = 1; step(); rst = 0;
    end else if (resp) begin
      while (cyc < t + 2 + NP + d) step();
      core_o_valid = 1; core_digit = dig; step();
      core_o_valid = 0; core_digit = 4'($urandom);
    end
    n = 0;
    while (t_start >= 0 && n < 5000) begin step(); n++; end
    if (t_start >= 0) begin
      checks++; errors++;
      $display("FAIL model_timeout cyc=%0d got=busy exp=idle", cyc);
    end
    repeat (3) step();
  endtask

  initial begin
    repeat (3) step();
    rst = 0; step();
    for (int i = 0; i < NP; i++) wr(i, DW'(i % 256));
    for (int i = NP; i < 1024; i += 37) wr(i, 8'hAA);
    run(10, 1, 4'd7, 0, -1, 1);
    run(0, 0, 4'd0, 0, -1, 2);
    run($urandom_range(TO - 2), 1, 4'd12, 0, -1, 3);
    run($urandom_range(TO - 2), 1, 4'($urandom_range(9)), 1, -1, 4);
    run($urandom_range(TO - 2), 1, 4'($urandom_range(9)), 0, -1, 5);
    run(0, 0, 4'd0, 0, 300, 6);
    run($urandom_range(TO - 2), 1, 4'd5, 0, -1, 7);
    run(TO - 1, 1, 4'd3, 0, -1, 8);
    run(0, 1, 4'($urandom_range(15)), 0, -1, 9);
    for (int i = 0; i < NP; i++) wr(i, DW'($urandom));
    for (int r = 0; r < 3; r++)
      run($urandom_range(TO - 1), 1, 4'($urandom_range(15)), r == 1, -1, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mnist_pixel_streamer.md
Name: mnist_pixel_streamer

Overview:
- Host-side driver for the MNIST accelerator core interface: the initiator that feeds the core's pixel input and collects its digit output.
- Holds one image in an internal NUM_PIXELS-entry buffer loaded over a simple write port.
- On start, resets the core, streams every pixel (one per cycle, with core_i_valid), then waits for core_o_valid and returns the classified digit.
- Sits between the testbench/host loader and the core.

Parameters:
- DATA_WIDTH, 8, pixel width; must match the core's pixel width.
- NUM_PIXELS, 784, pixels per image (28x28).
- TIMEOUT, 65535, maximum cycles to wait in WAIT for core_o_valid before aborting.

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  buffer write strobe
- wr_addr  input  $clog2(NUM_PIXELS)  buffer write address
- wr_data  input  DATA_WIDTH  buffer write data
- start  input  1  begin inference (single-cycle pulse)
- busy  output  1  high from start acceptance until result_valid
- core_rst  output  1  reset to core
- core_i_valid  output  1  pixel valid to core
- core_pixel  output  DATA_WIDTH  pixel to core
- core_o_valid  input  1  core result valid
- core_digit  input  4  core result digit
- result_valid  output  1  one-cycle result pulse
- result_digit  output  4  captured digit
- result_err  output  1  timeout or digit > 9

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: busy=0, core_i_valid=0, core_pixel=0, result_valid=0, result_digit=0, result_err=0. core_rst=1 while rst is high. FSM goes to IDLE; pixel counter and timeout counter are cleared. Buffer contents are not cleared.
- Buffer: synchronous write, synchronous one-cycle read.
  - Writes are accepted only in IDLE.
  - wr_en outside IDLE is ignored.
  - wr_addr >= NUM_PIXELS is ignored.
- FSM states: IDLE, CLR, STREAM, WAIT, DONE.
- IDLE: start=1 in cycle T -> CLR at T+1; busy=1 from T+1. start in any other state is ignored.
- CLR (one cycle, T+1):
  - core_rst=1.
  - Read of address 0 issued.
  - Move to STREAM.
- STREAM:
  - core_i_valid=1 for exactly NUM_PIXELS consecutive cycles, T+2 .. T+1+NUM_PIXELS.
  - core_pixel = buffer[k] in the k-th valid cycle, addresses 0..NUM_PIXELS-1 in order, no gaps.
  - core_pixel is registered and held at its last value when core_i_valid=0.
  - After the last pixel -> WAIT; core_i_valid=0 from T+2+NUM_PIXELS.
- WAIT:
  - Timeout counter increments each cycle.
  - core_o_valid=1 -> capture core_digit into result_digit; result_err = (core_digit > 9); go to DONE.
  - Counter reaches TIMEOUT with no core_o_valid -> result_digit=4'hF, result_err=1; go to DONE.
  - If core_o_valid arrives on the same cycle the counter reaches TIMEOUT, core_o_valid wins (result_err=0 if the digit is valid).
- DONE (one cycle):
  - result_valid=1.
  - busy drops to 0 in the same cycle.
  - Next state is IDLE. A start in DONE is ignored.
- result_digit and result_err hold their values until the next capture.
- core_o_valid in IDLE, CLR or STREAM is ignored; a stale result must not complete the next inference.
- Reset mid-operation (any state):
  - Next cycle: core_i_valid=0, busy=0, result_valid=0, FSM=IDLE.
  - core_rst is high for the reset cycle(s).
  - No result is produced for the aborted image.

Test Plan:
- Load buffer[i]=i mod 256, pulse start at T -> core_rst=1 at T+1; core_i_valid=1 for exactly 784 cycles from T+2; pixels 0,1,...,255,0,...,15 in order.
- After streaming, model core drives core_o_valid=1 with core_digit=7 ten cycles later -> result_valid single pulse next cycle, result_digit=7, result_err=0, busy=0.
- Core never responds, TIMEOUT=100 -> result_valid exactly 100 cycles after entering WAIT, result_digit=4'hF, result_err=1.
- core_digit=12 with core_o_valid -> result_digit=12, result_err=1.
- start pulses and wr_en writes during STREAM -> ignored; stream and buffer unchanged; second inference after DONE re-streams identical pixels.
- rst asserted at pixel 300 -> core_i_valid=0 and busy=0 next cycle, no result_valid; a subsequent start streams the full 784 pixels from address 0.
